// File: rtl/vliw_bundle_scheduler.sv
// vliw_bundle_scheduler
// Front-end for a 4-slot VLIW core. Scalar ops arrive in order on a
// valid/ready stream. They are buffered in a FIFO, and each cycle up to four
// of them are packed into one 128-bit bundle in program order. A bundle never
// contains an intra-bundle RAW or WAW hazard. MUL ops only go to slots whose
// MUL_SLOTS bit is set.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   in_valid       in_instr is valid
//   in_instr[31:0] [31]=valid [30:12]=imm19 [11:9]=src2 [8:6]=src1 [5:3]=dest [2:0]=op
//   in_ready       op accepted when in_valid && in_ready
//   hold           1 = issue nothing this cycle
//   bundle_o       registered bundle, slot s = bundle_o[32*s +: 32], empty slot = 0
//   bundle_valid   registered, 1 when bundle_o holds at least one op
//   bundle_cnt     non-empty bundles issued (saturating)
//   instr_cnt      ops issued (saturating)
//   drop_cnt       ops discarded at enqueue (saturating)
module vliw_bundle_scheduler #(
    parameter int         DEPTH     = 8,
    parameter logic [3:0] MUL_SLOTS = 4'b0011,
    parameter int         CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [31:0]        in_instr,
    output logic               in_ready,
    input  logic               hold,
    output logic [127:0]       bundle_o,
    output logic               bundle_valid,
    output logic [CNT_W-1:0]   bundle_cnt,
    output logic [CNT_W-1:0]   instr_cnt,
    output logic [CNT_W-1:0]   drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_MOV  = 3'b100;

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [127:0]     bundle_q, bundle_d;
    logic             bundle_valid_q, bundle_valid_d;
    logic [CNT_W-1:0] bundle_cnt_q, bundle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic        op_legal, push, drop, issue;
    logic [2:0]  pop_k;
    logic [31:0] head_entry [4];
    logic [3:0]  head_present;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Head window: the first four FIFO entries, present only if count covers them.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_head
            logic [PTR_W-1:0] idx;
            assign idx              = rd_ptr_q + PTR_W'(gi);
            assign head_entry[gi]   = mem_q[idx];
            assign head_present[gi] = (count_q > (PTR_W+1)'(gi));
        end
    endgenerate

    // Packer: walk the head window in order, stop at the first hazard or
    // the first MUL with no MUL-capable slot left.
    logic [127:0] pack_bundle;
    logic [2:0]   pack_k;
    logic [7:0]   wr_mask, rd_mask;
    logic [3:0]   slot_used;
    logic         stop, is_mul, found;
    logic [1:0]   slot_sel;
    logic [2:0]   op_i, dst_i, s1_i, s2_i;

    always_comb begin
        pack_bundle = '0;
        pack_k      = '0;
        wr_mask     = '0;
        rd_mask     = '0;
        slot_used   = '0;
        stop        = 1'b0;
        is_mul      = 1'b0;
        found       = 1'b0;
        slot_sel    = '0;
        op_i        = '0;
        dst_i       = '0;
        s1_i        = '0;
        s2_i        = '0;
        for (int i = 0; i < 4; i++) begin
            op_i   = head_entry[i][2:0];
            dst_i  = head_entry[i][5:3];
            s1_i   = head_entry[i][8:6];
            s2_i   = head_entry[i][11:9];
            is_mul = (op_i == OP_MUL);
            rd_mask = '0;
            if (op_i == OP_ADD || op_i == OP_MUL)
                rd_mask = (8'b1 << s1_i) | (8'b1 << s2_i);
            else if (op_i == OP_ADDI)
                rd_mask = 8'b1 << s1_i;
            // Preferred slot: MUL-capable for MUL, non-MUL-capable otherwise,
            // so plain ops leave the MUL slots free for later MULs.
            found    = 1'b0;
            slot_sel = '0;
            for (int s = 0; s < 4; s++) begin
                if (!found && !slot_used[s] && (MUL_SLOTS[s] == is_mul)) begin
                    found    = 1'b1;
                    slot_sel = 2'(s);
                end
            end
            if (!is_mul) begin
                for (int s = 0; s < 4; s++) begin
                    if (!found && !slot_used[s]) begin
                        found    = 1'b1;
                        slot_sel = 2'(s);
                    end
                end
            end
            if (head_present[i] && !stop) begin
                if ((rd_mask & wr_mask) != 8'b0 || wr_mask[dst_i] || !found) begin
                    stop = 1'b1;
                end else begin
                    pack_bundle[32*slot_sel +: 32] = head_entry[i];
                    slot_used[slot_sel]            = 1'b1;
                    wr_mask[dst_i]                 = 1'b1;
                    pack_k                         = pack_k + 3'd1;
                end
            end
        end
    end

    always_comb begin
        in_ready = !rst && (count_q < (PTR_W+1)'(DEPTH));
        op_legal = in_instr[31] && (in_instr[2:0] == OP_ADD || in_instr[2:0] == OP_MUL ||
                                    in_instr[2:0] == OP_ADDI || in_instr[2:0] == OP_MOV);
        push     = in_valid && in_ready && op_legal;
        drop     = in_valid && in_ready && !op_legal;
        issue    = !hold && (count_q != '0);
        pop_k    = issue ? pack_k : 3'd0;

        rd_ptr_d = rd_ptr_q + PTR_W'(pop_k);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop_k);

        bundle_d       = issue ? pack_bundle : 128'h0;
        bundle_valid_d = issue;
        bundle_cnt_d   = sat_add(bundle_cnt_q, {2'b00, issue});
        instr_cnt_d    = sat_add(instr_cnt_q, pop_k);
        drop_cnt_d     = sat_add(drop_cnt_q, {2'b00, drop});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            bundle_q       <= '0;
            bundle_valid_q <= 1'b0;
            bundle_cnt_q   <= '0;
            instr_cnt_q    <= '0;
            drop_cnt_q     <= '0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            bundle_q       <= bundle_d;
            bundle_valid_q <= bundle_valid_d;
            bundle_cnt_q   <= bundle_cnt_d;
            instr_cnt_q    <= instr_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    // Storage has no reset; stale entries are masked by count_q.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= in_instr;
    end

    assign bundle_o     = bundle_q;
    assign bundle_valid = bundle_valid_q;
    assign bundle_cnt   = bundle_cnt_q;
    assign instr_cnt    = instr_cnt_q;
    assign drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_vliw_bundle_scheduler.sv
// Testbench for vliw_bundle_scheduler (DEPTH=8, MUL_SLOTS=4'b0011).
// Expected bundles are queued as stimulus is driven and popped whenever the
// DUT presents a valid bundle; idle cycles must show an all-zero bundle.
module tb_vliw_bundle_scheduler;
    localparam int CNT_W = 16;
    localparam logic [2:0] ADD = 3'b000, MUL = 3'b001, ADDI = 3'b010, MOV = 3'b100;

    logic             clk = 1'b0;
    logic             rst, in_valid, hold, in_ready, bundle_valid;
    logic [31:0]      in_instr;
    logic [127:0]     bundle_o;
    logic [CNT_W-1:0] bundle_cnt, instr_cnt, drop_cnt;

    vliw_bundle_scheduler #(.DEPTH(8), .MUL_SLOTS(4'b0011), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .hold(hold), .bundle_o(bundle_o),
        .bundle_valid(bundle_valid), .bundle_cnt(bundle_cnt),
        .instr_cnt(instr_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int exp_bundle = 0, exp_instr = 0, exp_drop = 0;
    logic [127:0] sb [$];

    function automatic logic [31:0] enc(input logic [2:0] op, input logic [2:0] dest,
                                        input logic [2:0] src1, input logic [2:0] src2, input int imm);
        logic [18:0] im;
        im = imm[18:0];
        return {1'b1, im, src2, src1, dest, op};
    endfunction

    function automatic logic [127:0] mk(input logic [31:0] s0, input logic [31:0] s1,
                                        input logic [31:0] s2, input logic [31:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: wait for the edge, sample on the falling edge, score the output.
    task automatic step();
        logic [127:0] e;
        int n;
        @(posedge clk);
        @(negedge clk);
        if (bundle_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            chk("bundle", bundle_o, e);
            n = 0;
            for (int s = 0; s < 4; s++) if (e[32*s +: 32] != 32'h0) n++;
            exp_bundle++;
            exp_instr += n;
        end else if (bundle_valid !== 1'b0) begin
            chk("unexpected_bundle_valid", 128'(bundle_valid), 128'd0);
        end else begin
            chk("idle_bundle_zero", bundle_o, 128'h0);
        end
        chk("bundle_cnt", 128'(bundle_cnt), 128'(exp_bundle));
        chk("instr_cnt", 128'(instr_cnt), 128'(exp_instr));
        chk("drop_cnt", 128'(drop_cnt), 128'(exp_drop));
    endtask

    task automatic push(input logic [31:0] ins);
        chk("in_ready_before_push", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_instr = ins;
        step();
        in_valid = 1'b0;
        in_instr = 32'h0;
    endtask

    task automatic push_drop(input logic [31:0] ins);
        chk("in_ready_before_drop", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_instr = ins;
        exp_drop++;
        step();
        in_valid = 1'b0;
        in_instr = 32'h0;
    endtask

    // Bounded drain: a missing bundle shows up as a non-empty scoreboard.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
        chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        logic [31:0] a, b, c, d;
        logic [31:0] q [8];

        rst = 1'b1; in_valid = 1'b0; hold = 1'b0; in_instr = 32'h0;
        step();
        step();
        chk("in_ready_in_reset", 128'(in_ready), 128'd0);
        rst = 1'b0;
        step();
        chk("in_ready_after_reset", 128'(in_ready), 128'd1);

        // Four independent ops fill all four slots in a single bundle.
        a = enc(MOV, 3'd1, 3'd0, 3'd0, 5);
        b = enc(MOV, 3'd2, 3'd0, 3'd0, 7);
        c = enc(ADDI, 3'd3, 3'd0, 3'd0, 1);
        d = enc(MOV, 3'd4, 3'd0, 3'd0, 9);
        hold = 1'b1;
        push(a); push(b); push(c); push(d);
        hold = 1'b0;
        sb.push_back(mk(c, d, a, b));
        step();
        step();
        chk("t1_instr_cnt", 128'(instr_cnt), 128'd4);
        chk("t1_bundle_cnt", 128'(bundle_cnt), 128'd1);

        // RAW splits into two bundles.
        a = enc(MOV, 3'd1, 3'd0, 3'd0, 5);
        b = enc(ADD, 3'd2, 3'd1, 3'd1, 0);
        hold = 1'b1;
        push(a); push(b);
        hold = 1'b0;
        sb.push_back(mk(32'h0, 32'h0, a, 32'h0));
        sb.push_back(mk(32'h0, 32'h0, b, 32'h0));
        drain(4);

        // WAW splits; WAR shares a bundle.
        a = enc(MOV, 3'd1, 3'd0, 3'd0, 1);
        b = enc(MOV, 3'd1, 3'd0, 3'd0, 2);
        hold = 1'b1;
        push(a); push(b);
        hold = 1'b0;
        sb.push_back(mk(32'h0, 32'h0, a, 32'h0));
        sb.push_back(mk(32'h0, 32'h0, b, 32'h0));
        drain(4);
        a = enc(ADD, 3'd2, 3'd1, 3'd1, 0);
        b = enc(MOV, 3'd1, 3'd0, 3'd0, 3);
        hold = 1'b1;
        push(a); push(b);
        hold = 1'b0;
        sb.push_back(mk(32'h0, 32'h0, a, b));
        drain(3);

        // MUL slot limit: third MUL waits for the next bundle.
        a = enc(ADD, 3'd5, 3'd0, 3'd0, 0);
        b = enc(MUL, 3'd1, 3'd2, 3'd3, 0);
        c = enc(MUL, 3'd4, 3'd2, 3'd3, 0);
        d = enc(MUL, 3'd6, 3'd2, 3'd3, 0);
        hold = 1'b1;
        push(a); push(b); push(c); push(d);
        hold = 1'b0;
        sb.push_back(mk(b, c, a, 32'h0));
        sb.push_back(mk(d, 32'h0, 32'h0, 32'h0));
        drain(4);

        // Drops: cleared valid bit, then an unsupported opcode.
        a = enc(MOV, 3'd3, 3'd0, 3'd0, 11);
        a[31] = 1'b0;
        b = enc(3'b011, 3'd3, 3'd1, 3'd2, 12);
        push_drop(a);
        push_drop(b);
        drain(3);
        chk("t5_drop_cnt", 128'(drop_cnt), 128'd2);
        chk("t5_in_ready", 128'(in_ready), 128'd1);

        // Fill under hold: the ninth op is refused.
        for (int i = 0; i < 8; i++) q[i] = enc(MOV, 3'(i), 3'd0, 3'd0, 100 + i);
        hold = 1'b1;
        for (int i = 0; i < 8; i++) push(q[i]);
        chk("t6_full_in_ready", 128'(in_ready), 128'd0);
        in_valid = 1'b1;
        in_instr = enc(MOV, 3'd7, 3'd0, 3'd0, 999);
        step();
        in_valid = 1'b0;
        in_instr = 32'h0;
        chk("t6_still_full", 128'(in_ready), 128'd0);
        hold = 1'b0;
        sb.push_back(mk(q[2], q[3], q[0], q[1]));
        sb.push_back(mk(q[6], q[7], q[4], q[5]));
        drain(4);
        chk("t6_in_ready_after_drain", 128'(in_ready), 128'd1);

        // Refill, issue one bundle, then reset mid-drain.
        for (int i = 0; i < 8; i++) q[i] = enc(MOV, 3'(i), 3'd0, 3'd0, 200 + i);
        hold = 1'b1;
        for (int i = 0; i < 8; i++) push(q[i]);
        hold = 1'b0;
        sb.push_back(mk(q[2], q[3], q[0], q[1]));
        step();
        rst = 1'b1;
        exp_bundle = 0; exp_instr = 0; exp_drop = 0;
        step();
        chk("rst_bundle_cnt", 128'(bundle_cnt), 128'd0);
        chk("rst_instr_cnt", 128'(instr_cnt), 128'd0);
        chk("rst_bundle_o", bundle_o, 128'h0);
        rst = 1'b0;
        drain(5);
        chk("post_rst_in_ready", 128'(in_ready), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
